// File: rtl/g726_pkg.sv
// Shared G.726 constants and field types for the tone/transition detector datapath.
package g726_pkg;

   localparam logic [15:0] TONE_THR_DEF = 16'hD200;
   localparam logic [3:0]  YLINT_SAT    = 4'd9;
   localparam logic [14:0] DQTHR_SAT    = 15'h7C00;

   typedef logic [15:0] a2p_t;
   typedef logic [18:0] yl_t;
   typedef logic [15:0] dq_t;

endpackage

// File: rtl/tran_dq_thr.sv
// Transition threshold from the slow scale factor: 1.5 * 2^YL, halved, saturating for large YLINT.
module tran_dq_thr
   import g726_pkg::*;
(
   input  yl_t         yl,
   output logic [14:0] dqthr
);

   logic [3:0]  ylint;
   logic [4:0]  ylfrac;
   logic [15:0] thr1;
   logic [15:0] thr2;
   logic [15:0] sum;
   logic        unused_yl_low;

   assign unused_yl_low = ^yl[9:0];

   always_comb begin
      ylint  = yl[18:15];
      ylfrac = yl[14:10];
      // Shifts above YLINT_SAT can overflow, but that result is discarded below.
      thr1   = {10'd0, 1'b1, ylfrac} << ylint;
      thr2   = (ylint > YLINT_SAT) ? {1'b0, DQTHR_SAT} : thr1;
      sum    = thr2 + (thr2 >> 1);
      dqthr  = sum[15:1];
   end

endmodule

// File: rtl/ton_tran_det_mc.sv
// Multi-channel tone/transition detector: two-stage pipeline, per-channel TD bits with
// stage-2 -> stage-1 bypass, per-channel saturating TR event counters and channel clear.
module ton_tran_det_mc
   import g726_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter logic [15:0] TONE_THR = TONE_THR_DEF,
   parameter int unsigned CNT_W    = 8
)(
   input  logic             CLK,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [CH_W-1:0]  in_ch,
   input  a2p_t             A2P,
   input  yl_t              YL,
   input  dq_t              DQ,
   input  logic             ch_clr,
   input  logic [CH_W-1:0]  clr_ch,
   output logic             out_valid,
   output logic [CH_W-1:0]  out_ch,
   output logic             TDP,
   output logic             TR,
   input  logic [CH_W-1:0]  cnt_sel,
   output logic [CNT_W-1:0] cnt_q
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              s1_valid;
   logic              s1_ok;
   logic              s1_tdp;
   logic              s1_td;
   logic [CH_W-1:0]   s1_ch;
   logic [14:0]       s1_dqmag;
   logic [14:0]       s1_dqthr;

   logic [14:0]       dqthr;
   logic [NUM_CH-1:0] td_q;
   logic [CNT_W-1:0]  cnt_r [NUM_CH];

   logic              in_ok;
   logic              sel_ok;
   logic              tdp_in;
   logic              td_rd;
   logic              s2_we;
   logic              s2_tr;
   logic              s2_wr_td;
   logic              unused_dq_sign;

   assign unused_dq_sign = DQ[15];
   assign in_ok  = (32'(in_ch) < NUM_CH);
   assign sel_ok = (32'(cnt_sel) < NUM_CH);

   tran_dq_thr u_dq_thr (
      .yl    (YL),
      .dqthr (dqthr)
   );

   always_comb begin
      tdp_in   = A2P[15] && (A2P < TONE_THR);
      s2_we    = s1_valid && s1_ok;
      s2_tr    = s2_we && s1_td && (s1_dqmag > s1_dqthr);
      s2_wr_td = s2_tr ? 1'b0 : s1_tdp;
      // Storage, then the in-flight stage-2 write, then a same-edge clear: last one wins.
      td_rd = 1'b0;
      if (in_ok)
         td_rd = td_q[in_ch];
      if (s2_we && (s1_ch == in_ch))
         td_rd = s2_wr_td;
      if (ch_clr && (clr_ch == in_ch))
         td_rd = 1'b0;
   end

   always_ff @(posedge CLK or negedge rstn) begin
      if (!rstn) begin
         s1_valid  <= 1'b0;
         s1_ok     <= 1'b0;
         s1_tdp    <= 1'b0;
         s1_td     <= 1'b0;
         s1_ch     <= '0;
         s1_dqmag  <= '0;
         s1_dqthr  <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         TR        <= 1'b0;
         TDP       <= 1'b0;
         cnt_q     <= '0;
         td_q      <= '0;
         for (int i = 0; i < NUM_CH; i++)
            cnt_r[i] <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_ch    <= in_ch;
            s1_ok    <= in_ok;
            s1_tdp   <= tdp_in;
            s1_td    <= td_rd;
            s1_dqmag <= DQ[14:0];
            s1_dqthr <= dqthr;
         end
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_ch <= s1_ch;
            TR     <= s2_tr;
            TDP    <= s1_tdp;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_clr && (clr_ch == CH_W'(i))) begin
               td_q[i]  <= 1'b0;
               cnt_r[i] <= '0;
            end else if (s2_we && (s1_ch == CH_W'(i))) begin
               td_q[i] <= s2_wr_td;
               if (s2_tr && (cnt_r[i] != CNT_MAX))
                  cnt_r[i] <= cnt_r[i] + 1'b1;
            end
         end
         cnt_q <= sel_ok ? cnt_r[cnt_sel] : '0;
      end
   end

endmodule

// File: tb/tb_ton_tran_det_mc.sv
// Directed bench for ton_tran_det_mc: stimulus pushes expected {ch,TR,TDP}, a negedge monitor pops and compares.
module tb_ton_tran_det_mc;

   localparam int CH_W = 2;
   localparam int W    = CH_W + 2;

   logic            CLK = 1'b0;
   logic            rstn;
   logic            in_valid;
   logic [CH_W-1:0] in_ch;
   logic [15:0]     A2P;
   logic [18:0]     YL;
   logic [15:0]     DQ;
   logic            ch_clr;
   logic [CH_W-1:0] clr_ch;
   logic            out_valid;
   logic [CH_W-1:0] out_ch;
   logic            TDP;
   logic            TR;
   logic [CH_W-1:0] cnt_sel;
   logic [7:0]      cnt_q;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   ton_tran_det_mc dut (
      .CLK       (CLK),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ch     (in_ch),
      .A2P       (A2P),
      .YL        (YL),
      .DQ        (DQ),
      .ch_clr    (ch_clr),
      .clr_ch    (clr_ch),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .TDP       (TDP),
      .TR        (TR),
      .cnt_sel   (cnt_sel),
      .cnt_q     (cnt_q)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one sample for one cycle and record its expected {ch,TR,TDP}.
   task automatic send(input logic [1:0] ch, input logic [15:0] a2p, input logic [18:0] yl,
                       input logic [15:0] dq, input logic clr, input logic [1:0] cch,
                       input logic tr, input logic tdp);
      in_valid = 1'b1;
      in_ch    = ch;
      A2P      = a2p;
      YL       = yl;
      DQ       = dq;
      ch_clr   = clr;
      clr_ch   = cch;
      exp_q.push_back({ch, tr, tdp});
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      ch_clr   = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   task automatic check_cnt(input logic [1:0] ch, input logic [7:0] exp, input string name);
      cnt_sel = ch;
      @(negedge CLK);
      check(name, cnt_q, exp);
   endtask

   // Monitor: every valid output must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (rstn && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got ch=%0d TR=%0b TDP=%0b with no expectation", out_ch, TR, TDP);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_ch_tr_tdp", {out_ch, TR, TDP}, mon_e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn     = 1'b1;
      in_valid = 1'b0;
      in_ch    = '0;
      A2P      = '0;
      YL       = '0;
      DQ       = '0;
      ch_clr   = 1'b0;
      clr_ch   = '0;
      cnt_sel  = '0;
      #1 rstn  = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_out_valid", out_valid, 0);
      check("rst_tr", TR, 0);
      check("rst_tdp", TDP, 0);
      check("rst_cnt_q", cnt_q, 0);
      rstn = 1'b1;
      @(negedge CLK);

      // Tone threshold edges on ch0 (YL=0, DQ=0 so TR never fires).
      send(0, 16'hD1FF, 19'h0, 16'h0000, 0, 0, 0, 1);
      send(0, 16'hD200, 19'h0, 16'h0000, 0, 0, 0, 0);
      send(0, 16'h8000, 19'h0, 16'h0000, 0, 0, 0, 1);
      send(0, 16'h7FFF, 19'h0, 16'h0000, 0, 0, 0, 0);
      idle(3);

      // Small scale: DQTHR = 24.
      send(1, 16'h9000, 19'h0, 16'h0000, 0, 0, 0, 1);
      send(1, 16'h9000, 19'h0, 16'h0018, 0, 0, 0, 1);
      send(1, 16'h9000, 19'h0, 16'h8019, 0, 0, 1, 1);
      idle(3);
      check_cnt(1, 8'd1, "cnt1_small");

      // Saturated scale: DQTHR = 0x5D00.
      send(1, 16'h9000, 19'h50000, 16'h0000, 0, 0, 0, 1);
      send(1, 16'h9000, 19'h50000, 16'h5D00, 0, 0, 0, 1);
      send(1, 16'h9000, 19'h50000, 16'h5D01, 0, 0, 1, 1);
      idle(3);
      check_cnt(1, 8'd2, "cnt1_sat_scale");

      // Back-to-back ch2 through the bypass.
      send(2, 16'h9000, 19'h0, 16'h0000, 0, 0, 0, 1);
      send(2, 16'h9000, 19'h0, 16'h7FFF, 0, 0, 1, 1);
      send(2, 16'h9000, 19'h0, 16'h7FFF, 0, 0, 0, 1);
      idle(3);
      check_cnt(2, 8'd1, "cnt2_bypass");

      // Clear of stored state: TD2=1 and cnt2=1 are wiped by a clear riding on a ch0 sample.
      send(0, 16'h0000, 19'h0, 16'h0000, 1, 2, 0, 0);
      idle(2);
      send(2, 16'h0000, 19'h0, 16'h7FFF, 0, 0, 0, 0);
      idle(3);
      check_cnt(2, 8'd0, "cnt2_cleared");

      // Clear colliding with a ch3 TR in stage 2: output keeps TR, counter and TD end at 0.
      send(3, 16'h9000, 19'h0, 16'h0000, 0, 0, 0, 1);
      send(3, 16'h0000, 19'h0, 16'h7FFF, 0, 0, 1, 0);
      send(3, 16'h9000, 19'h0, 16'h7FFF, 1, 3, 0, 1);
      idle(3);
      check_cnt(3, 8'd0, "cnt3_clear_wins");

      // Counter run on ch0: 100 events, then 200 more to saturate.
      for (int i = 0; i < 100; i++) begin
         send(0, 16'h9000, 19'h0, 16'h0000, 0, 0, 0, 1);
         send(0, 16'h9000, 19'h0, 16'h7FFF, 0, 0, 1, 1);
      end
      idle(3);
      check_cnt(0, 8'd100, "cnt0_100");
      for (int i = 0; i < 200; i++) begin
         send(0, 16'h9000, 19'h0, 16'h0000, 0, 0, 0, 1);
         send(0, 16'h9000, 19'h0, 16'h7FFF, 0, 0, 1, 1);
      end
      idle(3);
      check_cnt(0, 8'hFF, "cnt0_saturated");

      // Reset mid-stream: outputs drop immediately, in-flight samples are dropped.
      send(0, 16'h9000, 19'h0, 16'h0000, 0, 0, 0, 1);
      send(0, 16'h9000, 19'h0, 16'h0000, 0, 0, 0, 1);
      send(0, 16'h9000, 19'h0, 16'h0000, 0, 0, 0, 1);
      check("pre_rst_tdp", TDP, 1);
      #2;
      rstn     = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_tr", TR, 0);
      check("mid_rst_tdp", TDP, 0);
      check("mid_rst_cnt_q", cnt_q, 0);
      repeat (2) @(negedge CLK);
      rstn = 1'b1;
      @(negedge CLK);
      check_cnt(0, 8'd0, "cnt0_after_rst");

      // First sample after reset: TD0 was reset, so no TR; output exactly 2 cycles later.
      send(0, 16'h9000, 19'h0, 16'h7FFF, 0, 0, 0, 1);
      in_valid = 1'b0;
      check("lat_plus1_out_valid", out_valid, 0);
      @(negedge CLK);
      check("lat_plus2_out_valid", out_valid, 1);
      idle(4);

      check("drain_exp_q", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
